seven_sensor_sweep: RTL
=======================

SEVEN_SENSOR_SWEEP -- requirements
Module: seven_sensor_sweep

Interface
REQ-001 Parameter: SETTLE, default 1, number of clock cycles a vector is held before the response is sampled (legal 1..15).
REQ-002 Clock  input  1  system clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  run request; sampled only in IDLE or DONE.
REQ-005 FIn  input  1  response f from the seven-sensor voter under test.
REQ-006 X1..X7  output  1 each  sensor levels driven to the voter; X1 = vector bit 0 ... X7 = vector bit 6.
REQ-007 Busy  output  1  sweep in progress.
REQ-008 Done  output  1  sweep complete; held until the next Start or Reset.
REQ-009 Pass  output  1  Done and zero mismatches.
REQ-010 MismatchCount  output  8  number of vectors whose sampled FIn differed from expected.
REQ-011 FailSeen  output  1  at least one mismatch recorded this run.
REQ-012 FirstFail  output  7  vector index of the first mismatch; 0 when FailSeen=0.

Function
REQ-013 The block SHALL sweep all 128 7-bit vectors in ascending order 0..127, driving each onto X7..X1 from registers (no combinational path from any input to X).
REQ-014 The expected response for vector v SHALL be 1 when at least two of the seven bits are 0 (popcount(v) <= 5), else 0.
REQ-015 States SHALL be IDLE, HOLD, DONE; IDLE and DONE are not Busy, HOLD has Busy=1.
REQ-016 In IDLE and DONE, X1..X7 SHALL all be driven 1 (no sensor low, voter output inactive).
REQ-017 IDLE/DONE with Start=1 at edge k: from edge k, state=HOLD, vector=0, hold counter=0, MismatchCount=0, FailSeen=0, FirstFail=0, Done=0, Pass=0.
REQ-018 Each vector SHALL be driven for exactly SETTLE+1 cycles; FIn SHALL be sampled at the edge ending that window (hold counter = SETTLE), never earlier.
REQ-019 At the sample edge, on FIn != expected: MismatchCount increments by 1; if FailSeen=0, FirstFail takes the vector index and FailSeen becomes 1.
REQ-020 At the sample edge of vectors 0..126, the vector SHALL increment by 1 and the hold counter SHALL clear; a full run takes 128*(SETTLE+1) cycles from Start edge to Done edge.
REQ-021 At the sample edge of vector 127 (mismatch included): state=DONE, Busy=0, Done=1, Pass=1 iff final MismatchCount=0, X returns to all 1.
REQ-022 Start while in HOLD SHALL be ignored; the run continues unaltered.
REQ-023 MismatchCount SHALL not wrap (maximum attainable value 128 fits in 8 bits).
REQ-024 Results (MismatchCount, FailSeen, FirstFail, Pass) SHALL remain stable in DONE until the next Start or Reset.

Reset
REQ-025 Reset=1 at any edge, including mid-run, SHALL force: state=IDLE, X1..X7=1, Busy=0, Done=0, Pass=0, MismatchCount=0, FailSeen=0, FirstFail=0, vector=0, hold counter=0.
REQ-026 Reset SHALL take priority over Start in the same cycle.

Verification
REQ-027 Correct voter loopback, SETTLE=1, Start pulse -> Busy for 256 cycles, Done=1, Pass=1, MismatchCount=0, FailSeen=0.
REQ-028 FIn tied 0 -> MismatchCount=120, FailSeen=1, FirstFail=0, Pass=0; FIn tied 1 -> MismatchCount=8, FirstFail=63, Pass=0.
REQ-029 Voter missing the ~X1&~X5 term -> MismatchCount=1, FirstFail=110 (7'h6E), Pass=0.
REQ-030 SETTLE=3, voter with 2-cycle registered output -> Pass=1 and run length 512 cycles; same voter at SETTLE=1 -> MismatchCount>0.
REQ-031 Reset asserted at vector 40 mid-run -> next cycle IDLE, X=7'h7F, all status 0; Start after -> fresh run from vector 0 with correct results.
REQ-032 Start pulses during HOLD and a Start in DONE -> HOLD pulses have no effect; DONE Start clears results and reruns with identical final values.

Source files
------------

// File: rtl/seven_sensor_sweep.sv
// Exhaustive tester for a seven-input "at least two sensors low" voter: sweeps
// all 128 sensor vectors, compares the voter response and reports mismatches.
module seven_sensor_sweep #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       FIn,
    output logic       X1,
    output logic       X2,
    output logic       X3,
    output logic       X4,
    output logic       X5,
    output logic       X6,
    output logic       X7,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [7:0] MismatchCount,
    output logic       FailSeen,
    output logic [6:0] FirstFail
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state_q;
    state_t     state_d;
    logic [6:0] vec_q;
    logic [6:0] x_q;
    logic [3:0] hold_q;
    logic [7:0] mismatch_q;
    logic       fail_seen_q;
    logic [6:0] first_fail_q;

    logic       run_start;
    logic       sample;
    logic       expected;
    logic       mismatch;
    logic       last_vec;

    assign run_start = (state_q != HOLD) && Start;
    assign sample    = (state_q == HOLD) && (hold_q == SETTLE_CNT);
    assign expected  = ($countones(vec_q) <= 5);
    assign mismatch  = sample && (FIn != expected);
    assign last_vec  = (vec_q == 7'd127);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = HOLD;
            HOLD:    if (sample && last_vec) state_d = DONE;
            DONE:    if (Start) state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_q == HOLD);
        Done = (state_q == DONE);
        Pass = (state_q == DONE) && (mismatch_q == 8'd0);
    end

    // The sensor pattern lives in its own register so X never sees a
    // combinational path from Start or FIn; it parks at all-ones outside a run.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            vec_q        <= 7'd0;
            x_q          <= 7'h7F;
            hold_q       <= 4'd0;
            mismatch_q   <= 8'd0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= 7'd0;
        end else if (run_start) begin
            vec_q        <= 7'd0;
            x_q          <= 7'd0;
            hold_q       <= 4'd0;
            mismatch_q   <= 8'd0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= 7'd0;
        end else if (state_q == HOLD) begin
            if (sample) begin
                hold_q <= 4'd0;
                if (last_vec) begin
                    x_q <= 7'h7F;
                end else begin
                    vec_q <= vec_q + 7'd1;
                    x_q   <= vec_q + 7'd1;
                end
            end else begin
                hold_q <= hold_q + 4'd1;
            end
            if (mismatch) begin
                if (mismatch_q != 8'hFF) begin
                    mismatch_q <= mismatch_q + 8'd1;
                end
                if (!fail_seen_q) begin
                    fail_seen_q  <= 1'b1;
                    first_fail_q <= vec_q;
                end
            end
        end
    end

    assign X1 = x_q[0];
    assign X2 = x_q[1];
    assign X3 = x_q[2];
    assign X4 = x_q[3];
    assign X5 = x_q[4];
    assign X6 = x_q[5];
    assign X7 = x_q[6];

    assign MismatchCount = mismatch_q;
    assign FailSeen      = fail_seen_q;
    assign FirstFail     = first_fail_q;

endmodule
